// File: rtl/rx_byte_assembler.sv
// Packs per-bit frame_decode events LSB first into bytes, checks ISO/IEC 14443A
// odd parity and emits registered by-byte soc/data/eoc/error events.
module rx_byte_assembler #(
  parameter bit PARITY_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_soc,
  input  logic       in_eoc,
  input  logic       in_error,
  input  logic       in_data_valid,
  input  logic       in_data,
  output logic       out_soc,
  output logic       out_eoc,
  output logic       out_error,
  output logic       out_data_valid,
  output logic [7:0] out_data,
  output logic [2:0] out_data_bits
);

  typedef enum logic [1:0] {IDLE, RX, ERR} state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] sr_q, sr_d;
  logic [7:0] byte_w;
  logic       soc_q, soc_d, eoc_q, eoc_d, err_q, err_d, dv_q, dv_d;
  logic [7:0] data_q, data_d;
  logic [2:0] bits_q, bits_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    soc_d   = 1'b0;
    eoc_d   = 1'b0;
    err_d   = 1'b0;
    dv_d    = 1'b0;
    data_d  = 8'h00;
    bits_d  = 3'd0;
    // Bits land at their final position, so a partial byte is already right-aligned
    // with zeros above it.
    byte_w  = sr_q;
    byte_w[cnt_q[2:0]] = in_data;

    if (in_soc) begin
      soc_d   = 1'b1;
      state_d = RX;
      cnt_d   = 4'd0;
      sr_d    = 8'h00;
    end else begin
      case (state_q)
        RX: begin
          if (in_eoc) begin
            eoc_d   = 1'b1;
            state_d = IDLE;
            cnt_d   = 4'd0;
            sr_d    = 8'h00;
            if (in_error || cnt_q == 4'd8) begin
              err_d = 1'b1;
            end else if (cnt_q != 4'd0) begin
              dv_d   = 1'b1;
              data_d = sr_q;
              bits_d = cnt_q[2:0];
            end
          end else if (in_error) begin
            err_d   = 1'b1;
            state_d = ERR;
          end else if (in_data_valid) begin
            if (cnt_q == 4'd8) begin
              cnt_d = 4'd0;
              sr_d  = 8'h00;
              if (in_data == ~^sr_q) begin
                dv_d   = 1'b1;
                data_d = sr_q;
              end else begin
                err_d   = 1'b1;
                state_d = ERR;
              end
            end else if (cnt_q == 4'd7) begin
              if (PARITY_EN) begin
                sr_d  = byte_w;
                cnt_d = 4'd8;
              end else begin
                dv_d   = 1'b1;
                data_d = byte_w;
                sr_d   = 8'h00;
                cnt_d  = 4'd0;
              end
            end else begin
              sr_d  = byte_w;
              cnt_d = cnt_q + 4'd1;
            end
          end
        end
        ERR: begin
          // The error was already reported when ERR was entered.
          if (in_eoc) begin
            eoc_d   = 1'b1;
            state_d = IDLE;
            cnt_d   = 4'd0;
            sr_d    = 8'h00;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      sr_q    <= 8'h00;
      soc_q   <= 1'b0;
      eoc_q   <= 1'b0;
      err_q   <= 1'b0;
      dv_q    <= 1'b0;
      data_q  <= 8'h00;
      bits_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      soc_q   <= soc_d;
      eoc_q   <= eoc_d;
      err_q   <= err_d;
      dv_q    <= dv_d;
      data_q  <= data_d;
      bits_q  <= bits_d;
    end
  end

  assign out_soc        = soc_q;
  assign out_eoc        = eoc_q;
  assign out_error      = err_q;
  assign out_data_valid = dv_q;
  assign out_data       = data_q;
  assign out_data_bits  = bits_q;

endmodule
